mpx_hilo_unit: RTL and testbench
================================

# mpx_hilo_unit

Architectural HI/LO register block sitting directly downstream of the MPX multiplier. It tracks MULT/MULTU operations in flight, captures the multiplier writeback into HI/LO, and executes MTHI/MTLO/MFHI/MFLO. HI/LO accesses are interlocked behind outstanding multiplies via a stall output. MFHI/MFLO results go to the integer writeback path with one cycle of latency.

## Interface
- MULT_STAGES, 2, multiplier issue-to-writeback latency in non-held cycles (2 or 3); sizes pending counter
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- opcode_valid_i  input  1  instruction presented this cycle
- opcode_opcode_i  input  32  instruction word
- opcode_invalid_i  input  1  instruction faulted; treated as not present
- opcode_rd_idx_i  input  5  destination GPR for MFHI/MFLO
- opcode_rs_operand_i  input  32  source value for MTHI/MTLO
- hold_i  input  1  pipeline freeze; all state holds
- mul_writeback_valid_i  input  1  multiplier result valid
- mul_writeback_hi_i  input  32  multiplier result [63:32]
- mul_writeback_lo_i  input  32  multiplier result [31:0]
- stall_o  output  1  instruction cannot be accepted this cycle (combinational)
- writeback_valid_o  output  1  MFHI/MFLO result valid
- writeback_rd_idx_o  output  5  destination GPR
- writeback_value_o  output  32  HI or LO value
- hi_o  output  32  current HI
- lo_o  output  32  current LO

## Operation
- Decode: SPECIAL opcode with func MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, using the codebase's mpx_defs.v field macros. Instructions other than these are ignored.
- Accept = opcode_valid_i & ~opcode_invalid_i & ~hold_i & ~stall_o & decoded instruction.
- Pending counter:
  - Width $clog2(MULT_STAGES+1).
  - Increments on an accepted MULT/MULTU.
  - Decrements on mul_writeback_valid_i & ~hold_i.
  - On both in the same cycle, it is unchanged.
  - Decrement at 0 saturates at 0; this is an illegal input and the bench must flag it.
- stall_o = opcode_valid_i & ~opcode_invalid_i & (MFHI|MFLO|MTHI|MTLO) & (pending != 0). MULT/MULTU never stall, and back-to-back multiplies are allowed. stall_o is independent of hold_i.
- Multiplier writeback: on mul_writeback_valid_i & ~hold_i, HI ← mul_writeback_hi_i and LO ← mul_writeback_lo_i.
- MTHI/MTLO (accepted): HI or LO ← opcode_rs_operand_i at the clock edge. This cannot collide with a multiplier writeback, because the stall guarantees pending==0.
- MFHI/MFLO (accepted): the next cycle drives writeback_valid_o=1, writeback_rd_idx_o=opcode_rd_idx_i, and writeback_value_o=HI or LO. The value sampled is the pre-edge register value.
- In a non-held cycle with no accepted MFHI/MFLO, writeback_valid_o is 0; idx and value are don't-care but are driven to 0.
- hi_o/lo_o are the registered values.

## Timing
- Reset: HI=0, LO=0, pending=0, writeback_valid_o=0, writeback_rd_idx_o=0, writeback_value_o=0. stall_o is 0 while pending=0.
- Reset mid-operation: any in-flight multiply is forgotten. A later stray mul_writeback_valid_i is the upstream's responsibility, since the multiplier resets too.
- MFHI/MFLO latency: 1 cycle from accept to writeback_valid_o.
- MTHI/MTLO: visible on hi_o/lo_o 1 cycle after accept.
- MULT→MFLO back-to-back with MULT_STAGES=2:
  - MULT accepted at cycle N.
  - mul valid at N+2.
  - MFLO stalls at N+1 and N+2, is accepted at N+3, and writeback appears at N+4.
- No bypass from mul_writeback into the same-cycle accept decision. pending must reach 0 first.
- hold_i=1: HI, LO, pending and all writeback outputs keep their values. Accept is suppressed. stall_o still evaluates.
- Simultaneous MULT accept and mul writeback: HI/LO take the completing result, and pending is unchanged.
- Counter never exceeds MULT_STAGES in legal use.

## Test plan
- Reset then idle → hi_o=lo_o=0, writeback_valid_o=0, stall_o=0 with MFHI presented.
- MTHI rs=0xDEADBEEF, then MFHI rd=5 → hi_o=0xDEADBEEF one cycle after MTHI. Next cycle writeback_valid_o=1, rd_idx=5, value=0xDEADBEEF.
- MULT, then MFLO rd=3 immediately; mul writeback hi=0xFFFFFFFF, lo=0xFFFFFFFA two cycles after MULT:
  - stall_o=1 for 2 cycles.
  - MFLO writes back 0xFFFFFFFA to rd 3.
  - pending returns to 0.
- Three back-to-back MULTs, with writebacks 0x1/0x2, 0x3/0x4, 0x5/0x6 → pending never exceeds 2. Final HI=0x5, LO=0x6. MFHI stalls until the last writeback, then returns 0x5.
- hold_i asserted for 3 cycles during a pending MULT with mul valid high → HI/LO unchanged until hold releases. pending drops only on the first non-held valid cycle.
- opcode_invalid_i=1 with MTLO → LO unchanged, no stall, no writeback.

Source files
------------

// File: rtl/mpx_hilo_unit.sv
// mpx_hilo_unit
// Architectural HI/LO register block placed directly after the MPX multiplier.
// It counts MULT/MULTU operations still in flight and captures the multiplier
// writeback into HI/LO. It also executes MTHI/MTLO/MFHI/MFLO.
// HI/LO accesses stall while any multiply is outstanding.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   opcode_valid_i               instruction presented this cycle
//   opcode_opcode_i              instruction word
//   opcode_invalid_i             instruction faulted (treated as absent)
//   opcode_rd_idx_i              destination GPR for MFHI/MFLO
//   opcode_rs_operand_i          source value for MTHI/MTLO
//   hold_i                       pipeline freeze; all state holds
//   mul_writeback_valid_i/_hi_i/_lo_i  multiplier result
//   stall_o                      instruction cannot be accepted (combinational)
//   writeback_valid_o/_rd_idx_o/_value_o  MFHI/MFLO result, one cycle after accept
//   hi_o, lo_o                   current HI / LO
//
// Handshake: an instruction is taken on a rising edge when it is valid, is not
// invalid, hold_i is low, stall_o is low and it decodes as a HI/LO or multiply
// op. The issuer keeps presenting a stalled instruction until it is taken.
// There is no valid/ready back-pressure on the multiplier writeback. The
// writeback is consumed on any non-held cycle where it is valid.
module mpx_hilo_unit #(
  parameter int MULT_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic        opcode_invalid_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [31:0] opcode_rs_operand_i,
  input  logic        hold_i,
  input  logic        mul_writeback_valid_i,
  input  logic [31:0] mul_writeback_hi_i,
  input  logic [31:0] mul_writeback_lo_i,
  output logic        stall_o,
  output logic        writeback_valid_o,
  output logic [4:0]  writeback_rd_idx_o,
  output logic [31:0] writeback_value_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CNT_W = $clog2(MULT_STAGES + 1);

  // Instruction fields: primary opcode [31:26], function [5:0].
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;

  logic [5:0] op_field;
  logic [5:0] fn_field;
  logic       is_special;
  logic       dec_mfhi, dec_mthi, dec_mflo, dec_mtlo, dec_mult;
  logic       is_hilo_op;
  logic       present;
  logic       accept;
  logic       mul_wb;
  logic       unused_instr_bits;

  logic [CNT_W-1:0] pending_q, pending_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_idx_q, wb_idx_d;
  logic [31:0]      wb_val_q, wb_val_d;

  assign op_field          = opcode_opcode_i[31:26];
  assign fn_field          = opcode_opcode_i[5:0];
  assign unused_instr_bits = ^opcode_opcode_i[25:6];

  assign is_special = (op_field == OP_SPECIAL);
  assign dec_mfhi   = is_special && (fn_field == FN_MFHI);
  assign dec_mthi   = is_special && (fn_field == FN_MTHI);
  assign dec_mflo   = is_special && (fn_field == FN_MFLO);
  assign dec_mtlo   = is_special && (fn_field == FN_MTLO);
  assign dec_mult   = is_special && ((fn_field == FN_MULT) || (fn_field == FN_MULTU));
  assign is_hilo_op = dec_mfhi | dec_mthi | dec_mflo | dec_mtlo;

  assign present = opcode_valid_i & ~opcode_invalid_i;
  // stall_o ignores hold_i. A HI/LO op waits until every multiply has written
  // back. There is no bypass from a writeback arriving in the same cycle.
  assign stall_o = present & is_hilo_op & (pending_q != '0);
  assign accept  = present & ~hold_i & ~stall_o & (is_hilo_op | dec_mult);
  assign mul_wb  = mul_writeback_valid_i & ~hold_i;

  always_comb begin
    pending_d  = pending_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    wb_valid_d = wb_valid_q;
    wb_idx_d   = wb_idx_q;
    wb_val_d   = wb_val_q;
    if (!hold_i) begin
      wb_valid_d = 1'b0;
      wb_idx_d   = '0;
      wb_val_d   = '0;
      if (accept && (dec_mfhi || dec_mflo)) begin
        wb_valid_d = 1'b1;
        wb_idx_d   = opcode_rd_idx_i;
        wb_val_d   = dec_mfhi ? hi_q : lo_q;
      end
      // A legal MTHI/MTLO only runs with nothing pending, so it never meets a
      // writeback. If a stray writeback does arrive, the writeback wins.
      if (mul_wb) begin
        hi_d = mul_writeback_hi_i;
        lo_d = mul_writeback_lo_i;
      end else begin
        if (accept && dec_mthi) hi_d = opcode_rs_operand_i;
        if (accept && dec_mtlo) lo_d = opcode_rs_operand_i;
      end
      // An issue and a completion in the same cycle cancel out. A completion
      // with nothing pending is upstream misuse, and the counter saturates at 0.
      if (accept && dec_mult && !mul_wb) begin
        pending_d = pending_q + 1'b1;
      end else if (!(accept && dec_mult) && mul_wb && (pending_q != '0)) begin
        pending_d = pending_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_val_q   <= '0;
    end else begin
      pending_q  <= pending_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_val_q   <= wb_val_d;
    end
  end

  assign writeback_valid_o  = wb_valid_q;
  assign writeback_rd_idx_o = wb_idx_q;
  assign writeback_value_o  = wb_val_q;
  assign hi_o               = hi_q;
  assign lo_o               = lo_q;

endmodule

// File: tb/tb_mpx_hilo_unit.sv
module tb_mpx_hilo_unit;

  localparam int MULT_STAGES = 2;
  localparam int N_VEC       = 30;
  localparam int N_RAND      = 600;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        op_valid;
  logic [31:0] op_word;
  logic        op_invalid;
  logic [4:0]  op_rd;
  logic [31:0] op_rs;
  logic        hold;
  logic        mwv;
  logic [31:0] mhi;
  logic [31:0] mlo;
  logic        stall;
  logic        wbv;
  logic [4:0]  wb_idx;
  logic [31:0] wb_val;
  logic [31:0] hi;
  logic [31:0] lo;

  mpx_hilo_unit #(.MULT_STAGES(MULT_STAGES)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .opcode_valid_i        (op_valid),
    .opcode_opcode_i       (op_word),
    .opcode_invalid_i      (op_invalid),
    .opcode_rd_idx_i       (op_rd),
    .opcode_rs_operand_i   (op_rs),
    .hold_i                (hold),
    .mul_writeback_valid_i (mwv),
    .mul_writeback_hi_i    (mhi),
    .mul_writeback_lo_i    (mlo),
    .stall_o               (stall),
    .writeback_valid_o     (wbv),
    .writeback_rd_idx_o    (wb_idx),
    .writeback_value_o     (wb_val),
    .hi_o                  (hi),
    .lo_o                  (lo)
  );

  int n_vec = 0;
  int n_mis = 0;

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk_instr(input logic special, input logic [5:0] fn);
    // The non-SPECIAL form keeps the same low bits, so it only differs in the primary opcode.
    mk_instr = special ? {26'h0, fn} : {6'h02, 20'h0, fn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic inv, input logic h, input logic [31:0] instr,
                       input logic [4:0] rd, input logic [31:0] rs,
                       input logic mv, input logic [31:0] mh, input logic [31:0] ml);
    op_valid   = v;
    op_invalid = inv;
    hold       = h;
    op_word    = instr;
    op_rd      = rd;
    op_rs      = rs;
    mwv        = mv;
    mhi        = mh;
    mlo        = ml;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic e_wbv, input logic [4:0] e_idx, input logic [31:0] e_val);
    chk({tag, "_hi"}, hi, e_hi);
    chk({tag, "_lo"}, lo, e_lo);
    chk({tag, "_wbv"}, {31'b0, wbv}, {31'b0, e_wbv});
    chk({tag, "_idx"}, {27'b0, wb_idx}, {27'b0, e_idx});
    chk({tag, "_val"}, wb_val, e_val);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        valid;
    logic        invalid;
    logic        hold;
    logic        special;
    logic [5:0]  fn;
    logic [4:0]  rd;
    logic [31:0] rs;
    logic        mwv;
    logic [31:0] mhi;
    logic [31:0] mlo;
    logic        e_stall;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_wbv;
    logic [4:0]  e_idx;
    logic [31:0] e_val;
  } vec_t;

  vec_t vecs[N_VEC];

  function automatic vec_t mkv(input logic v, input logic inv, input logic h, input logic sp,
                               input logic [5:0] fn, input logic [4:0] rd, input logic [31:0] rs,
                               input logic mv, input logic [31:0] mh, input logic [31:0] ml,
                               input logic es, input logic [31:0] eh, input logic [31:0] el,
                               input logic ew, input logic [4:0] ei, input logic [31:0] ev);
    vec_t r;
    r.valid = v; r.invalid = inv; r.hold = h; r.special = sp; r.fn = fn; r.rd = rd; r.rs = rs;
    r.mwv = mv; r.mhi = mh; r.mlo = ml;
    r.e_stall = es; r.e_hi = eh; r.e_lo = el; r.e_wbv = ew; r.e_idx = ei; r.e_val = ev;
    return r;
  endfunction

  // The expected hi/lo/writeback values are the ones after the row's clock edge.
  // The expected stall is the value before that edge.
  task automatic fill_table();
    vecs[0]  = mkv(1,0,0,1,F_MFHI, 1,0,           0,0,0,                 0,0,0,                       1,1,0);
    vecs[1]  = mkv(1,0,0,1,F_MTHI, 0,32'hDEADBEEF,0,0,0,                 0,32'hDEADBEEF,0,            0,0,0);
    vecs[2]  = mkv(1,0,0,1,F_MFHI, 5,0,           0,0,0,                 0,32'hDEADBEEF,0,            1,5,32'hDEADBEEF);
    vecs[3]  = mkv(1,0,0,1,F_MULT, 0,0,           0,0,0,                 0,32'hDEADBEEF,0,            0,0,0);
    vecs[4]  = mkv(1,0,0,1,F_MFLO, 3,0,           0,0,0,                 1,32'hDEADBEEF,0,            0,0,0);
    vecs[5]  = mkv(1,0,0,1,F_MFLO, 3,0,           1,32'hFFFFFFFF,32'hFFFFFFFA, 1,32'hFFFFFFFF,32'hFFFFFFFA, 0,0,0);
    vecs[6]  = mkv(1,0,0,1,F_MFLO, 3,0,           0,0,0,                 0,32'hFFFFFFFF,32'hFFFFFFFA, 1,3,32'hFFFFFFFA);
    vecs[7]  = mkv(0,0,0,1,F_MFHI, 0,0,           0,0,0,                 0,32'hFFFFFFFF,32'hFFFFFFFA, 0,0,0);
    vecs[8]  = mkv(1,0,0,1,F_MULT, 0,0,           0,0,0,                 0,32'hFFFFFFFF,32'hFFFFFFFA, 0,0,0);
    vecs[9]  = mkv(1,0,0,1,F_MULTU,0,0,           0,0,0,                 0,32'hFFFFFFFF,32'hFFFFFFFA, 0,0,0);
    vecs[10] = mkv(1,0,0,1,F_MULT, 0,0,           1,32'h1,32'h2,         0,32'h1,32'h2,               0,0,0);
    vecs[11] = mkv(1,0,0,1,F_MFHI, 7,0,           1,32'h3,32'h4,         1,32'h3,32'h4,               0,0,0);
    vecs[12] = mkv(1,0,0,1,F_MFHI, 7,0,           1,32'h5,32'h6,         1,32'h5,32'h6,               0,0,0);
    vecs[13] = mkv(1,0,0,1,F_MFHI, 7,0,           0,0,0,                 0,32'h5,32'h6,               1,7,32'h5);
    vecs[14] = mkv(1,1,0,1,F_MTLO, 0,32'h12345678,0,0,0,                 0,32'h5,32'h6,               0,0,0);
    vecs[15] = mkv(1,0,0,1,F_MTLO, 0,32'hCAFEF00D,0,0,0,                 0,32'h5,32'hCAFEF00D,        0,0,0);
    vecs[16] = mkv(1,0,0,1,F_ADD,  9,32'h99,      0,0,0,                 0,32'h5,32'hCAFEF00D,        0,0,0);
    vecs[17] = mkv(1,0,0,0,F_MTHI, 9,32'h99,      0,0,0,                 0,32'h5,32'hCAFEF00D,        0,0,0);
    vecs[18] = mkv(1,0,0,1,F_MULT, 0,0,           0,0,0,                 0,32'h5,32'hCAFEF00D,        0,0,0);
    vecs[19] = mkv(0,0,0,1,F_MFHI, 0,0,           0,0,0,                 0,32'h5,32'hCAFEF00D,        0,0,0);
    vecs[20] = mkv(1,0,1,1,F_MFHI, 2,0,           1,32'hAAAA0000,32'hBBBB0000, 1,32'h5,32'hCAFEF00D, 0,0,0);
    vecs[21] = mkv(1,0,1,1,F_MFHI, 2,0,           1,32'hAAAA0000,32'hBBBB0000, 1,32'h5,32'hCAFEF00D, 0,0,0);
    vecs[22] = mkv(1,0,1,1,F_MFHI, 2,0,           1,32'hAAAA0000,32'hBBBB0000, 1,32'h5,32'hCAFEF00D, 0,0,0);
    vecs[23] = mkv(1,0,0,1,F_MFHI, 2,0,           1,32'hAAAA0000,32'hBBBB0000, 1,32'hAAAA0000,32'hBBBB0000, 0,0,0);
    vecs[24] = mkv(1,0,0,1,F_MFHI, 2,0,           0,0,0,                 0,32'hAAAA0000,32'hBBBB0000, 1,2,32'hAAAA0000);
    vecs[25] = mkv(1,0,0,1,F_MFLO, 4,0,           0,0,0,                 0,32'hAAAA0000,32'hBBBB0000, 1,4,32'hBBBB0000);
    vecs[26] = mkv(1,0,1,1,F_MTHI, 0,32'h11111111,0,0,0,                 0,32'hAAAA0000,32'hBBBB0000, 1,4,32'hBBBB0000);
    vecs[27] = mkv(1,0,1,1,F_MULT, 0,0,           0,0,0,                 0,32'hAAAA0000,32'hBBBB0000, 1,4,32'hBBBB0000);
    vecs[28] = mkv(0,0,0,1,F_MFHI, 0,0,           0,0,0,                 0,32'hAAAA0000,32'hBBBB0000, 0,0,0);
    vecs[29] = mkv(1,0,0,1,F_MFHI, 1,0,           0,0,0,                 0,32'hAAAA0000,32'hBBBB0000, 1,1,32'hAAAA0000);
  endtask

  // ---------------- reference model for random stimulus ----------------
  // The multiplier is modelled as a queue of in-flight results. The age of each
  // entry counts the non-held edges since issue. The result is presented once
  // its age reaches MULT_STAGES and stays presented until a non-held cycle takes it.
  logic [31:0] m_hi, m_lo, m_val;
  logic        m_wbv;
  logic [4:0]  m_idx;
  int          age_q[$];
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];

  task automatic run_random();
    int          k;
    logic        v, inv, h, sp, hilo, mult, acc, e_stall, pmv;
    logic [5:0]  fn;
    logic [4:0]  rd;
    logic [31:0] rs, pmh, pml;
    m_hi = '0; m_lo = '0; m_wbv = 1'b0; m_idx = '0; m_val = '0;
    age_q.delete(); exp_hi_q.delete(); exp_lo_q.delete();
    for (int c = 0; c < N_RAND; c++) begin
      k    = $urandom_range(0, 7);
      sp   = (k != 7);
      case (k)
        0: fn = F_MFHI;  1: fn = F_MTHI;  2: fn = F_MFLO;  3: fn = F_MTLO;
        4: fn = F_MULT;  5: fn = F_MULTU; 6: fn = F_ADD;   default: fn = F_MFLO;
      endcase
      v    = ($urandom_range(0, 3) != 0);
      inv  = ($urandom_range(0, 9) == 0);
      h    = ($urandom_range(0, 7) == 0);
      rd   = 5'($urandom_range(0, 31));
      rs   = $urandom;
      pmv  = (age_q.size() > 0) && (age_q[0] >= MULT_STAGES);
      pmh  = pmv ? exp_hi_q[0] : $urandom;
      pml  = pmv ? exp_lo_q[0] : $urandom;
      drive(v, inv, h, mk_instr(sp, fn), rd, rs, pmv, pmh, pml);
      hilo = sp && (fn inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
      mult = sp && (fn inside {F_MULT, F_MULTU});
      e_stall = v && !inv && hilo && (age_q.size() != 0);
      #1 chk("rnd_stall", {31'b0, stall}, {31'b0, e_stall});
      if (!h) begin
        acc = v && !inv && (hilo || mult) && !e_stall;
        if (acc && sp && (fn == F_MFHI || fn == F_MFLO)) begin
          m_wbv = 1'b1; m_idx = rd; m_val = (fn == F_MFHI) ? m_hi : m_lo;
        end else begin
          m_wbv = 1'b0; m_idx = '0; m_val = '0;
        end
        if (pmv) begin
          if (age_q.size() == 0) begin
            n_mis++;
            $display("FAIL illegal_wb: writeback with nothing pending (t=%0t)", $time);
          end
          m_hi = pmh; m_lo = pml;
          void'(age_q.pop_front()); void'(exp_hi_q.pop_front()); void'(exp_lo_q.pop_front());
        end else begin
          if (acc && fn == F_MTHI) m_hi = rs;
          if (acc && fn == F_MTLO) m_lo = rs;
        end
        foreach (age_q[i]) if (age_q[i] < MULT_STAGES) age_q[i]++;
        if (acc && mult) begin
          age_q.push_back(1); exp_hi_q.push_back($urandom); exp_lo_q.push_back($urandom);
        end
        if (age_q.size() > MULT_STAGES) begin
          n_mis++;
          $display("FAIL pending_bound: %0d in flight, limit %0d", age_q.size(), MULT_STAGES);
        end
      end
      @(posedge clk);
      #1 chk_regs("rnd", m_hi, m_lo, m_wbv, m_idx, m_val);
    end
    // Drain the outstanding multiplies so the run ends quiescent.
    while (age_q.size() > 0) begin
      pmv = (age_q[0] >= MULT_STAGES);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, pmv, pmv ? exp_hi_q[0] : 32'h0,
            pmv ? exp_lo_q[0] : 32'h0);
      if (pmv) begin
        m_hi = exp_hi_q[0]; m_lo = exp_lo_q[0];
        void'(age_q.pop_front()); void'(exp_hi_q.pop_front()); void'(exp_lo_q.pop_front());
      end
      foreach (age_q[i]) if (age_q[i] < MULT_STAGES) age_q[i]++;
      @(posedge clk);
      #1 chk_regs("drain", m_hi, m_lo, 1'b0, 5'd0, 32'h0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    fill_table();
    reset_dut();

    // Reset state.
    chk_regs("reset", 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Directed table.
    for (int i = 0; i < N_VEC; i++) begin
      drive(vecs[i].valid, vecs[i].invalid, vecs[i].hold, mk_instr(vecs[i].special, vecs[i].fn),
            vecs[i].rd, vecs[i].rs, vecs[i].mwv, vecs[i].mhi, vecs[i].mlo);
      #1 chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
      @(posedge clk);
      #1 chk_regs($sformatf("v%0d", i), vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_wbv,
                  vecs[i].e_idx, vecs[i].e_val);
    end

    // Reset with a writeback result live clears the outputs and HI/LO.
    drive(1'b1, 1'b0, 1'b0, mk_instr(1'b1, F_MTHI), 5'd0, 32'h77, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 1'b0, mk_instr(1'b1, F_MFHI), 5'd6, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 chk_regs("pre_rst", 32'h77, 32'hBBBB0000, 1'b1, 5'd6, 32'h77);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_regs("rst_live", 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset with a multiply in flight forgets it, so a MFLO issued next does not stall.
    drive(1'b1, 1'b0, 1'b0, mk_instr(1'b1, F_MULT), 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, mk_instr(1'b1, F_MFLO), 5'd8, 32'h0, 1'b0, 32'h0, 32'h0);
    #1 chk("rst_pending_stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1 chk_regs("rst_pending", 32'h0, 32'h0, 1'b1, 5'd8, 32'h0);

    // Randomized traffic against the reference model.
    reset_dut();
    run_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
